// File: rtl/csr_mmode_unit.sv
`default_nettype none
// =====================================================================
// csr_mmode_unit : machine-mode CSR file with trap entry, mret and counters
// Rev 1.0
// =====================================================================
module csr_mmode_unit #(
  parameter int          DATA_W      = 64,
  parameter bit          VECTORED_EN = 1'b1,
  parameter int unsigned HART_ID     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_valid_i,
  input  logic [DATA_W-1:0] inst_addr_i,
  input  logic [1:0]        csr_ctrl_i,
  input  logic [11:0]       csr_index_i,
  input  logic [DATA_W-1:0] csr_wdata_i,
  input  logic              csr_src_zero_i,
  input  logic              ecall_i,
  input  logic              ebreak_i,
  input  logic              mret_i,
  input  logic              irq_msip_i,
  input  logic              irq_mtip_i,
  input  logic              irq_meip_i,
  output logic [DATA_W-1:0] csr_rdata_o,
  output logic              trap_o,
  output logic [DATA_W-1:0] trap_pc_o,
  output logic              illegal_o,
  output logic              retire_o
);

  localparam bit IS32 = (DATA_W == 32);

  localparam logic [11:0] ADDR_MVENDORID     = 12'hF11;
  localparam logic [11:0] ADDR_MARCHID       = 12'hF12;
  localparam logic [11:0] ADDR_MIMPID        = 12'hF13;
  localparam logic [11:0] ADDR_MHARTID       = 12'hF14;
  localparam logic [11:0] ADDR_MSTATUS       = 12'h300;
  localparam logic [11:0] ADDR_MISA          = 12'h301;
  localparam logic [11:0] ADDR_MIE           = 12'h304;
  localparam logic [11:0] ADDR_MTVEC         = 12'h305;
  localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] ADDR_MSCRATCH      = 12'h340;
  localparam logic [11:0] ADDR_MEPC          = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE        = 12'h342;
  localparam logic [11:0] ADDR_MIP           = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH     = 12'hB82;

  // MXL in the top two bits, I extension at bit 8
  localparam logic [DATA_W-1:0] MISA_VAL =
    {((DATA_W == 64) ? 2'd2 : 2'd1), {(DATA_W-11){1'b0}}, 1'b1, 8'd0};

  logic              mstatus_mie_q, mstatus_mie_d;
  logic              mstatus_mpie_q, mstatus_mpie_d;
  logic [DATA_W-3:0] mtvec_base_q, mtvec_base_d;
  logic              mtvec_mode_q, mtvec_mode_d;
  logic [DATA_W-3:0] mepc_q, mepc_d;
  logic [DATA_W-1:0] mcause_q, mcause_d;
  logic [2:0]        mie_q, mie_d;      // {MEIE, MTIE, MSIE}
  logic [2:0]        mip_q, mip_d;      // {MEIP, MTIP, MSIP}
  logic [DATA_W-1:0] mscratch_q, mscratch_d;
  logic              cy_q, cy_d;
  logic              ir_q, ir_d;
  logic [63:0]       mcycle_q, mcycle_d;
  logic [63:0]       minstret_q, minstret_d;

  logic [DATA_W-1:0] old_val;
  logic              implemented;
  logic              read_only;
  logic [DATA_W-1:0] csr_wval;
  logic              csr_write;
  logic              csr_illegal;
  logic [2:0]        irq_pend;
  logic              irq_take;
  logic              exc_illegal;
  logic              exc_ecall;
  logic              exc_ebreak;
  logic              trap_take;
  logic              mret_take;
  logic              csr_we;
  logic [3:0]        trap_cause;
  logic [DATA_W-1:0] trap_cause_val;
  logic [DATA_W-1:0] trap_base_pc;
  logic [DATA_W-1:0] trap_vec_pc;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^inst_addr_i[1:0];

  always_comb begin
    old_val     = '0;
    implemented = 1'b1;
    read_only   = 1'b0;
    case (csr_index_i)
      ADDR_MVENDORID: read_only = 1'b1;
      ADDR_MARCHID: begin
        old_val   = DATA_W'(1);
        read_only = 1'b1;
      end
      ADDR_MIMPID: read_only = 1'b1;
      ADDR_MHARTID: begin
        old_val   = DATA_W'(HART_ID);
        read_only = 1'b1;
      end
      ADDR_MISA: begin
        old_val   = MISA_VAL;
        read_only = 1'b1;
      end
      ADDR_MSTATUS: begin
        old_val[12:11] = 2'b11;
        old_val[7]     = mstatus_mpie_q;
        old_val[3]     = mstatus_mie_q;
      end
      ADDR_MIE: begin
        old_val[11] = mie_q[2];
        old_val[7]  = mie_q[1];
        old_val[3]  = mie_q[0];
      end
      ADDR_MIP: begin
        old_val[11] = mip_q[2];
        old_val[7]  = mip_q[1];
        old_val[3]  = mip_q[0];
      end
      ADDR_MTVEC:         old_val = {mtvec_base_q, 1'b0, mtvec_mode_q};
      ADDR_MEPC:          old_val = {mepc_q, 2'b00};
      ADDR_MCAUSE:        old_val = mcause_q;
      ADDR_MSCRATCH:      old_val = mscratch_q;
      ADDR_MCOUNTINHIBIT: begin
        old_val[2] = ir_q;
        old_val[0] = cy_q;
      end
      ADDR_MCYCLE:        old_val = DATA_W'(mcycle_q);
      ADDR_MINSTRET:      old_val = DATA_W'(minstret_q);
      ADDR_MCYCLEH: begin
        if (IS32) old_val = DATA_W'(mcycle_q[63:32]);
        else      implemented = 1'b0;
      end
      ADDR_MINSTRETH: begin
        if (IS32) old_val = DATA_W'(minstret_q[63:32]);
        else      implemented = 1'b0;
      end
      default: implemented = 1'b0;
    endcase
  end

  always_comb begin
    case (csr_ctrl_i)
      2'b01:   csr_wval = csr_wdata_i;
      2'b10:   csr_wval = old_val | csr_wdata_i;
      2'b11:   csr_wval = old_val & ~csr_wdata_i;
      default: csr_wval = old_val;
    endcase
  end

  // RS/RC with a zero operand is a pure read and never writes
  assign csr_write   = (csr_ctrl_i == 2'b01) || (csr_ctrl_i[1] && !csr_src_zero_i);
  assign csr_illegal = (csr_ctrl_i != 2'b00) && (!implemented || (csr_write && read_only));

  assign irq_pend    = mie_q & mip_q;
  assign irq_take    = inst_valid_i && mstatus_mie_q && (|irq_pend);
  assign exc_illegal = inst_valid_i && !irq_take && csr_illegal;
  assign exc_ecall   = inst_valid_i && !irq_take && !csr_illegal && ecall_i;
  assign exc_ebreak  = inst_valid_i && !irq_take && !csr_illegal && !ecall_i && ebreak_i;
  assign trap_take   = irq_take || exc_illegal || exc_ecall || exc_ebreak;
  assign mret_take   = inst_valid_i && !trap_take && mret_i;
  assign csr_we      = inst_valid_i && !trap_take && !mret_take && csr_write;

  always_comb begin
    trap_cause = 4'd0;
    if (irq_take) begin
      if (irq_pend[2])      trap_cause = 4'd11;
      else if (irq_pend[0]) trap_cause = 4'd3;
      else                  trap_cause = 4'd7;
    end else if (exc_illegal) begin
      trap_cause = 4'd2;
    end else if (exc_ecall) begin
      trap_cause = 4'd11;
    end else if (exc_ebreak) begin
      trap_cause = 4'd3;
    end
  end

  always_comb begin
    trap_cause_val           = '0;
    trap_cause_val[3:0]      = trap_cause;
    trap_cause_val[DATA_W-1] = irq_take;
  end

  assign trap_base_pc = {mtvec_base_q, 2'b00};
  assign trap_vec_pc  = (irq_take && mtvec_mode_q)
                      ? trap_base_pc + DATA_W'({trap_cause, 2'b00})
                      : trap_base_pc;

  assign csr_rdata_o = old_val;
  assign trap_o      = trap_take || mret_take;
  assign trap_pc_o   = trap_take ? trap_vec_pc : (mret_take ? {mepc_q, 2'b00} : '0);
  assign illegal_o   = exc_illegal;
  assign retire_o    = inst_valid_i && !trap_take;

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mtvec_base_d   = mtvec_base_q;
    mtvec_mode_d   = mtvec_mode_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mie_d          = mie_q;
    mip_d          = {irq_meip_i, irq_mtip_i, irq_msip_i};
    mscratch_d     = mscratch_q;
    cy_d           = cy_q;
    ir_d           = ir_q;
    mcycle_d       = cy_q ? mcycle_q : mcycle_q + 64'd1;
    minstret_d     = (retire_o && !ir_q) ? minstret_q + 64'd1 : minstret_q;

    if (trap_take) begin
      mepc_d         = inst_addr_i[DATA_W-1:2];
      mcause_d       = trap_cause_val;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret_take) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (csr_we) begin
      // an explicit counter write replaces the increment computed above
      case (csr_index_i)
        ADDR_MSTATUS: begin
          mstatus_mie_d  = csr_wval[3];
          mstatus_mpie_d = csr_wval[7];
        end
        ADDR_MTVEC: begin
          mtvec_base_d = csr_wval[DATA_W-1:2];
          mtvec_mode_d = VECTORED_EN && (csr_wval[1:0] == 2'b01);
        end
        ADDR_MEPC:     mepc_d     = csr_wval[DATA_W-1:2];
        ADDR_MCAUSE:   mcause_d   = csr_wval;
        ADDR_MIE:      mie_d      = {csr_wval[11], csr_wval[7], csr_wval[3]};
        ADDR_MSCRATCH: mscratch_d = csr_wval;
        ADDR_MCOUNTINHIBIT: begin
          ir_d = csr_wval[2];
          cy_d = csr_wval[0];
        end
        ADDR_MCYCLE:
          mcycle_d = IS32 ? {mcycle_q[63:32], 32'(csr_wval)} : 64'(csr_wval);
        ADDR_MINSTRET:
          minstret_d = IS32 ? {minstret_q[63:32], 32'(csr_wval)} : 64'(csr_wval);
        ADDR_MCYCLEH:   mcycle_d   = {32'(csr_wval), mcycle_q[31:0]};
        ADDR_MINSTRETH: minstret_d = {32'(csr_wval), minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mtvec_base_q   <= '0;
      mtvec_mode_q   <= 1'b0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mie_q          <= '0;
      mip_q          <= '0;
      mscratch_q     <= '0;
      cy_q           <= 1'b0;
      ir_q           <= 1'b0;
      mcycle_q       <= '0;
      minstret_q     <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mtvec_base_q   <= mtvec_base_d;
      mtvec_mode_q   <= mtvec_mode_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mie_q          <= mie_d;
      mip_q          <= mip_d;
      mscratch_q     <= mscratch_d;
      cy_q           <= cy_d;
      ir_q           <= ir_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csr_mmode_unit.sv
`default_nettype none
// tb_csr_mmode_unit : directed scoreboard bench for a 64-bit (HART_ID=3) and a 32-bit csr_mmode_unit
module tb_csr_mmode_unit;

  localparam int SEL_RDATA   = 0;
  localparam int SEL_TRAP    = 1;
  localparam int SEL_TPC     = 2;
  localparam int SEL_ILL     = 3;
  localparam int SEL_RET     = 4;
  localparam int SEL_RDATA32 = 5;
  localparam int SEL_TRAP32  = 6;
  localparam int SEL_TPC32   = 7;
  localparam int SEL_ILL32   = 8;
  localparam int SEL_RET32   = 9;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_valid = 1'b0;
  logic [63:0] inst_addr = '0;
  logic [1:0]  ctrl = '0;
  logic [11:0] idx = '0;
  logic [63:0] wdata = '0;
  logic        srcz = 1'b0;
  logic        ecall = 1'b0;
  logic        ebreak = 1'b0;
  logic        mret = 1'b0;
  logic        msip = 1'b0;
  logic        mtip = 1'b0;
  logic        meip = 1'b0;

  logic [63:0] rdata, tpc;
  logic        trap, ill, ret;
  logic [31:0] rdata32, tpc32;
  logic        trap32, ill32, ret32;

  always #5 clk = ~clk;

  csr_mmode_unit #(.DATA_W(64), .VECTORED_EN(1'b1), .HART_ID(3)) dut (
    .clk(clk), .rst(rst), .inst_valid_i(inst_valid), .inst_addr_i(inst_addr),
    .csr_ctrl_i(ctrl), .csr_index_i(idx), .csr_wdata_i(wdata), .csr_src_zero_i(srcz),
    .ecall_i(ecall), .ebreak_i(ebreak), .mret_i(mret),
    .irq_msip_i(msip), .irq_mtip_i(mtip), .irq_meip_i(meip),
    .csr_rdata_o(rdata), .trap_o(trap), .trap_pc_o(tpc), .illegal_o(ill), .retire_o(ret)
  );

  csr_mmode_unit #(.DATA_W(32), .VECTORED_EN(1'b1), .HART_ID(0)) dut32 (
    .clk(clk), .rst(rst), .inst_valid_i(inst_valid), .inst_addr_i(inst_addr[31:0]),
    .csr_ctrl_i(ctrl), .csr_index_i(idx), .csr_wdata_i(wdata[31:0]), .csr_src_zero_i(srcz),
    .ecall_i(ecall), .ebreak_i(ebreak), .mret_i(mret),
    .irq_msip_i(msip), .irq_mtip_i(mtip), .irq_meip_i(meip),
    .csr_rdata_o(rdata32), .trap_o(trap32), .trap_pc_o(tpc32), .illegal_o(ill32),
    .retire_o(ret32)
  );

  function automatic logic [63:0] observed(input int sel);
    case (sel)
      SEL_RDATA:   return rdata;
      SEL_TRAP:    return {63'd0, trap};
      SEL_TPC:     return tpc;
      SEL_ILL:     return {63'd0, ill};
      SEL_RET:     return {63'd0, ret};
      SEL_RDATA32: return {32'd0, rdata32};
      SEL_TRAP32:  return {63'd0, trap32};
      SEL_TPC32:   return {32'd0, tpc32};
      SEL_ILL32:   return {63'd0, ill32};
      SEL_RET32:   return {63'd0, ret32};
      default:     return 64'hDEAD_BEEF_DEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic op(input logic [1:0] c, input logic [11:0] i, input logic [63:0] d,
                    input logic z);
    inst_valid = 1'b1;
    ctrl       = c;
    idx        = i;
    wdata      = d;
    srcz       = z;
    ecall      = 1'b0;
    ebreak     = 1'b0;
    mret       = 1'b0;
    inst_addr  = 64'h100;
  endtask

  // compare everything queued for this cycle at the falling edge, then advance
  task automatic check_cycle();
    exp_t        e;
    logic [63:0] obs;
    @(negedge clk);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observed(e.sel);
      tests_run++;
      assert (obs === e.exp) else begin
        tests_failed++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [11:0] i, input logic [63:0] v);
    op(2'b10, i, 64'd0, 1'b1);
    push(tag, SEL_RDATA, v);
    check_cycle();
  endtask

  task automatic wr(input logic [11:0] i, input logic [63:0] d);
    op(2'b01, i, d, 1'b0);
    check_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idx = 12'h300;
    push("rst_mstatus", SEL_RDATA, 64'h1800);
    push("rst_trap", SEL_TRAP, 64'd0);
    push("rst_tpc", SEL_TPC, 64'd0);
    push("rst_ill", SEL_ILL, 64'd0);
    push("rst_ret", SEL_RET, 64'd0);
    check_cycle();
    rst = 1'b0;

    op(2'b10, 12'h301, 64'd0, 1'b1);
    push("misa64", SEL_RDATA, 64'h8000_0000_0000_0100);
    push("misa_ret", SEL_RET, 64'd1);
    check_cycle();
    rd("mhartid", 12'hF14, 64'd3);

    op(2'b01, 12'h340, 64'h0F, 1'b0);
    push("mscratch_rw_old", SEL_RDATA, 64'd0);
    check_cycle();
    op(2'b10, 12'h340, 64'hF0, 1'b0);
    push("mscratch_rs_old", SEL_RDATA, 64'h0F);
    check_cycle();
    rd("mscratch_after_rs", 12'h340, 64'hFF);
    op(2'b11, 12'h340, 64'h0F, 1'b0);
    push("mscratch_rc_old", SEL_RDATA, 64'hFF);
    check_cycle();
    rd("mscratch_after_rc", 12'h340, 64'hF0);

    op(2'b10, 12'hF11, 64'd0, 1'b1);
    push("mvendorid_rs0_ill", SEL_ILL, 64'd0);
    push("mvendorid_rs0_ret", SEL_RET, 64'd1);
    check_cycle();

    wr(12'h305, 64'h2002);
    rd("mtvec_mode2", 12'h305, 64'h2000);
    wr(12'h305, 64'h1001);
    rd("mtvec_vec", 12'h305, 64'h1001);
    wr(12'h341, 64'h1003);
    rd("mepc_align", 12'h341, 64'h1000);

    wr(12'h304, 64'h880);
    op(2'b10, 12'h300, 64'h8, 1'b0);
    check_cycle();

    op(2'b10, 12'h340, 64'd0, 1'b1);
    meip = 1'b1;
    mtip = 1'b1;
    push("irq_lag_trap", SEL_TRAP, 64'd0);
    push("irq_lag_rdata", SEL_RDATA, 64'hF0);
    check_cycle();
    op(2'b01, 12'h340, 64'h1234, 1'b0);
    inst_addr = 64'h4000;
    push("irq_trap", SEL_TRAP, 64'd1);
    push("irq_tpc", SEL_TPC, 64'h102C);
    push("irq_ret", SEL_RET, 64'd0);
    check_cycle();
    meip = 1'b0;
    mtip = 1'b0;
    rd("irq_mcause", 12'h342, 64'h8000_0000_0000_000B);
    rd("irq_mstatus", 12'h300, 64'h1880);
    rd("irq_mepc", 12'h341, 64'h4000);
    rd("irq_write_suppressed", 12'h340, 64'hF0);

    op(2'b10, 12'h300, 64'h8, 1'b0);
    check_cycle();
    op(2'b00, 12'h000, 64'd0, 1'b0);
    ecall = 1'b1;
    inst_addr = 64'h8000_0010;
    push("ecall_trap", SEL_TRAP, 64'd1);
    push("ecall_tpc", SEL_TPC, 64'h1000);
    push("ecall_ret", SEL_RET, 64'd0);
    check_cycle();
    rd("ecall_mstatus", 12'h300, 64'h1880);
    rd("ecall_mepc", 12'h341, 64'h8000_0010);
    rd("ecall_mcause", 12'h342, 64'd11);
    op(2'b00, 12'h000, 64'd0, 1'b0);
    mret = 1'b1;
    push("mret_trap", SEL_TRAP, 64'd1);
    push("mret_tpc", SEL_TPC, 64'h8000_0010);
    push("mret_ret", SEL_RET, 64'd1);
    check_cycle();
    rd("mret_mstatus", 12'h300, 64'h1888);
    op(2'b00, 12'h000, 64'd0, 1'b0);
    ebreak = 1'b1;
    push("ebreak_trap", SEL_TRAP, 64'd1);
    check_cycle();
    rd("ebreak_mcause", 12'h342, 64'd3);

    op(2'b01, 12'hF11, 64'd5, 1'b0);
    push("wr_ro_ill", SEL_ILL, 64'd1);
    push("wr_ro_trap", SEL_TRAP, 64'd1);
    push("wr_ro_tpc", SEL_TPC, 64'h1000);
    push("wr_ro_ret", SEL_RET, 64'd0);
    check_cycle();
    rd("ill_mcause", 12'h342, 64'd2);
    wr(12'hB02, 64'd100);
    op(2'b10, 12'h7FF, 64'd0, 1'b1);
    push("unimpl_ill", SEL_ILL, 64'd1);
    push("unimpl_ret", SEL_RET, 64'd0);
    check_cycle();
    rd("ill_no_retire", 12'hB02, 64'd100);
    op(2'b10, 12'hB80, 64'd0, 1'b1);
    push("mcycleh64_ill", SEL_ILL, 64'd1);
    push("mcycleh32_ill", SEL_ILL32, 64'd0);
    check_cycle();
    op(2'b01, 12'h344, 64'hFFF, 1'b0);
    push("mip_wr_ill", SEL_ILL, 64'd0);
    push("mip_wr_ret", SEL_RET, 64'd1);
    check_cycle();

    wr(12'h320, 64'h4);
    wr(12'hB02, 64'd500);
    wr(12'hB00, 64'd1000);
    rd("mcycle_start", 12'hB00, 64'd1000);
    for (int k = 0; k < 9; k++) rd("minstret_inhibited", 12'hB02, 64'd500);
    rd("mcycle_plus10", 12'hB00, 64'd1010);
    wr(12'h320, 64'h0);
    rd("minstret_resume0", 12'hB02, 64'd500);
    rd("minstret_resume1", 12'hB02, 64'd501);

    op(2'b10, 12'h301, 64'd0, 1'b1);
    push("misa32", SEL_RDATA32, 64'h4000_0100);
    check_cycle();
    op(2'b01, 12'hB80, 64'd7, 1'b0);
    push("mcycleh32_wr_ill", SEL_ILL32, 64'd0);
    push("mcycleh32_wr_trap", SEL_TRAP32, 64'd0);
    push("mcycleh32_wr_tpc", SEL_TPC32, 64'd0);
    push("mcycleh32_wr_ret", SEL_RET32, 64'd1);
    check_cycle();
    wr(12'hB00, 64'hFFFF_FFFF);
    op(2'b10, 12'hB80, 64'd0, 1'b1);
    push("mcycleh32_before", SEL_RDATA32, 64'd7);
    check_cycle();
    op(2'b10, 12'hB80, 64'd0, 1'b1);
    push("mcycleh32_carry", SEL_RDATA32, 64'd8);
    check_cycle();
    op(2'b10, 12'hB00, 64'd0, 1'b1);
    push("mcycle32_wrap", SEL_RDATA32, 64'd1);
    check_cycle();

    inst_valid = 1'b0;
    ctrl       = 2'b00;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
